rv32i_loadstore: RTL and testbench
==================================

// Module: rv32i_loadstore
// PURPOSE
//  Memory-access stage of the rv32i core: executes LOAD/STORE against a
//  word-wide data-memory bus with a req/ack handshake. It produces the
//  formatted data_load value consumed by writeback.
//  Stalls the pipeline while a bus transfer is outstanding.
//  Flags misaligned or illegal accesses without issuing a bus cycle.
// PARAMETERS
//  ADDR_W          32   data-bus address width (bits [ADDR_W-1:2] are driven)
//  TIMEOUT_CYCLES  255  watchdog limit in cycles, range 1..65535 (only with LS_TIMEOUT_EN)
// PORTS
//  clk        in   1       core clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle request from execute; sampled only in IDLE
//  opcode     in   7       LOAD=7'b000_0011, STORE=7'b010_0011; other values are ignored
//  funct3     in   3       access size and sign
//  addr       in   32      effective address (rs1+imm)
//  rs2        in   32      store data
//  stall      out  1       hold upstream pipeline
//  done       out  1       1-cycle pulse: access completed
//  data_load  out  32      formatted load result, registered
//  fault      out  1       1-cycle pulse: misaligned or illegal funct3
//  bus_err    out  1       1-cycle pulse: watchdog abort (0 without LS_TIMEOUT_EN)
//  d_req      out  1       bus request, held until ack
//  d_we       out  1       1=write
//  d_addr     out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
//  d_wdata    out  32      lane-replicated store data
//  d_be       out  4       byte enables
//  d_ack      in   1       bus accept/complete, single cycle
//  d_rdata    in   32      read data, valid when d_ack=1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including data_load.
//   Reset is asynchronous and can occur mid-transfer; d_req drops immediately.
//  FSM states: IDLE, REQ.
//   IDLE with start, a LOAD/STORE opcode and a legal, aligned access:
//    latch d_we/d_addr/d_wdata/d_be; go to REQ.
//   REQ: d_req=1 with all bus outputs stable.
//    d_ack=1 -> go to IDLE; done=1 in the next cycle.
//    LOAD additionally registers data_load in the same edge.
//  Latency: start at cycle 0, d_req at cycle 1.
//   If d_ack is sampled in cycle 1, done fires in cycle 2 (minimum latency 2).
//  stall = (state==REQ) | (state==IDLE & start & legal mem op).
//   stall is combinational and low in the done cycle.
//  start is ignored outside IDLE. Non-memory opcodes: no action, no pulses.
//  d_ack outside REQ is ignored.
//  Legal funct3 values:
//   LOAD: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//   STORE: 000 SB, 001 SH, 010 SW.
//  Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
//  Misaligned or illegal access:
//   fault=1 in the next cycle; no bus cycle; state stays IDLE; no stall.
//   data_load is unchanged.
//  Store lanes:
//   SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
//   SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{rs2[15:0]}}.
//   SW: be=4'b1111, wdata=rs2.
//  Loads: d_be=4'b1111; lane selected by addr[1:0].
//   LB/LH sign-extend; LBU/LHU zero-extend.
// CONFIGURATION
//  LS_TIMEOUT_EN defined:
//   A 16-bit counter runs in REQ.
//   If TIMEOUT_CYCLES elapse without d_ack: d_req drops, bus_err pulses 1 cycle,
//   and the FSM returns to IDLE. done does not pulse; data_load is unchanged.
//  LS_TIMEOUT_EN undefined: REQ waits indefinitely; bus_err is tied 0.
// TESTING
//  LW addr=0x100, d_rdata=0xDEADBEEF, ack in 1st REQ cycle
//   -> d_addr=0x100, be=1111; done in cycle 2; data_load=0xDEADBEEF.
//  LB addr=0x103, d_rdata=0x80xxxxxx -> data_load=0xFFFFFF80.
//   Same access as LBU -> data_load=0x00000080.
//  SH addr=0x22, rs2=0x1234ABCD
//   -> d_we=1, d_addr=0x20, be=1100, wdata=0xABCDABCD.
//   Ack after 3 wait cycles -> stall held 4 cycles, then done.
//  LW addr=0x102 -> fault pulse, d_req never rises, stall=0.
//   LOAD with funct3=011 -> fault pulse.
//  rst_n low during REQ -> d_req=0 immediately.
//   A later d_ack is ignored; no done pulse.
//  LS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and d_ack held 0
//   -> bus_err pulses after 4 REQ cycles; FSM back in IDLE.

Source files
------------

// File: rtl/rv32i_loadstore_if.sv
// ============================================================================
// Module      : rv32i_loadstore_if
// Description : Data-memory bus of the load/store stage (req/ack handshake).
//               The master drives request, direction, word address, write
//               data and byte enables. The slave returns a single-cycle ack
//               and the read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32i_loadstore_if #(
  parameter int ADDR_W = 32
);
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_ack;
  logic [31:0]       d_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_loadstore.sv
// ============================================================================
// Module      : rv32i_loadstore
// Description : rv32i memory-access stage. Executes LOAD/STORE on a word-wide
//               req/ack data bus, formats the load result, stalls upstream
//               while a transfer is outstanding, and flags misaligned or
//               illegal accesses without issuing a bus cycle.
//               Optional watchdog enabled by defining LS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_loadstore #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [6:0]  opcode,
  input  wire logic [2:0]  funct3,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] rs2,
  output logic             stall,
  output logic             done,
  output logic [31:0]      data_load,
  output logic             fault,
  output logic             bus_err,
  rv32i_loadstore_if.master bus
);

  localparam logic [6:0] OP_LOAD  = 7'b000_0011;
  localparam logic [6:0] OP_STORE = 7'b010_0011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       data_load_q, data_load_d;

  logic              is_load, is_store, legal_f3, aligned, mem_op, go;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       rd_lane;
  logic [31:0]       ld_fmt;
  logic              timeout;

  // Decode the incoming request: memory op, funct3 legality and alignment
  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    legal_f3 = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        default:                                legal_f3 = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        default:                legal_f3 = 1'b0;
      endcase
    end
    // funct3[1:0] encodes the size for both loads and stores
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    mem_op = start & (is_load | is_store);
    go     = mem_op & legal_f3 & aligned;
  end

  // Store lane placement; loads always enable the whole word
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << addr[1:0];
          st_wdata = {4{rs2[7:0]}};
        end
        2'b01: begin
          st_be    = addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{rs2[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = rs2;
        end
      endcase
    end
  end

  // Select the addressed lane of the read word and sign/zero extend it
  always_comb begin
    rd_lane = bus.d_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_fmt = {{24{rd_lane[7]}}, rd_lane[7:0]};
      3'b001:  ld_fmt = {{16{rd_lane[15]}}, rd_lane[15:0]};
      3'b100:  ld_fmt = {24'h0, rd_lane[7:0]};
      3'b101:  ld_fmt = {16'h0, rd_lane[15:0]};
      default: ld_fmt = bus.d_rdata;
    endcase
  end

`ifdef LS_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // Watchdog counts REQ cycles; restarts every time a transfer begins
  always_comb begin
    cnt_d   = (state_q == REQ) ? cnt_q + 16'd1 : 16'd0;
    timeout = (state_q == REQ) && (cnt_q == TO_LIMIT);
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign timeout               = 1'b0;
`endif

  // Next-state logic: request capture, handshake completion and pulses
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    bus_err_d   = 1'b0;
    data_load_d = data_load_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = REQ;
          we_d     = is_store;
          addr_d   = {addr[ADDR_W-1:2], 2'b00};
          wdata_d  = st_wdata;
          be_d     = st_be;
          funct3_d = funct3;
          off_d    = addr[1:0];
        end else if (mem_op) begin
          fault_d = 1'b1;
        end
      end
      REQ: begin
        if (bus.d_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!we_q) data_load_d = ld_fmt;
        end else if (timeout) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      funct3_q    <= 3'h0;
      off_q       <= 2'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      data_load_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      bus_err_q   <= bus_err_d;
      data_load_q <= data_load_d;
    end
  end

  // d_req comes straight from the state flop so reset drops it at once
  assign bus.d_req   = (state_q == REQ);
  assign bus.d_we    = we_q;
  assign bus.d_addr  = addr_q;
  assign bus.d_wdata = wdata_q;
  assign bus.d_be    = be_q;

  assign stall     = (state_q == REQ) | ((state_q == IDLE) & go);
  assign done      = done_q;
  assign fault     = fault_q;
  assign bus_err   = bus_err_q;
  assign data_load = data_load_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_loadstore.sv
// ============================================================================
// Module      : tb_rv32i_loadstore
// Description : Directed self-checking bench for rv32i_loadstore.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_loadstore;

  localparam logic [6:0] OP_LOAD  = 7'b000_0011;
  localparam logic [6:0] OP_STORE = 7'b010_0011;
  localparam logic [6:0] OP_ALU   = 7'b011_0011;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic        stall;
  logic        done;
  logic [31:0] data_load;
  logic        fault;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_loadstore_if #(.ADDR_W(32)) bus_if ();

`ifdef LS_TIMEOUT_EN
  rv32i_loadstore #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
`else
  rv32i_loadstore #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .funct3    (funct3),
    .addr      (addr),
    .rs2       (rs2),
    .stall     (stall),
    .done      (done),
    .data_load (data_load),
    .fault     (fault),
    .bus_err   (bus_err),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Advance to 1ns after the next rising edge and drop one-shot inputs
  task automatic next_cycle();
    @(posedge clk);
    #1;
    start         = 1'b0;
    bus_if.d_ack  = 1'b0;
  endtask

  // Present a request for the current cycle (cycle 0)
  task automatic drive_start(input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
    start  = 1'b1;
    opcode = op;
    funct3 = f3;
    addr   = a;
    rs2    = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({stall, done, fault, bus_err} !== 4'b0000) begin
      $display("FAIL reset_pulses: got %b expected 0000", {stall, done, fault, bus_err});
      n_fail++;
    end
    n_checks++;
    if (data_load !== 32'h0) begin
      $display("FAIL reset_data_load: got %h expected 00000000", data_load);
      n_fail++;
    end
    n_checks++;
    if ({bus_if.d_req, bus_if.d_we, bus_if.d_be} !== 6'b0 || bus_if.d_addr !== 32'h0 ||
        bus_if.d_wdata !== 32'h0) begin
      $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wdata=%h expected all 0",
               bus_if.d_req, bus_if.d_we, bus_if.d_be, bus_if.d_addr, bus_if.d_wdata);
      n_fail++;
    end
    #1 rst_n = 1'b1;
    next_cycle();
  endtask

  // One load with ack in the first REQ cycle; checks address, latency, result
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    drive_start(OP_LOAD, f3, a, 32'h0);
    #1;
    n_checks++;
    if (stall !== 1'b1 || bus_if.d_req !== 1'b0) begin
      $display("FAIL %s_cycle0: got stall=%b req=%b expected stall=1 req=0", name, stall, bus_if.d_req);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (bus_if.d_req !== 1'b1 || bus_if.d_we !== 1'b0 || bus_if.d_be !== 4'b1111 ||
        bus_if.d_addr !== {a[31:2], 2'b00}) begin
      $display("FAIL %s_bus: got req=%b we=%b be=%b addr=%h expected 1 0 1111 %h",
               name, bus_if.d_req, bus_if.d_we, bus_if.d_be, bus_if.d_addr, {a[31:2], 2'b00});
      n_fail++;
    end
    bus_if.d_ack   = 1'b1;
    bus_if.d_rdata = rdata;
    next_cycle();
    n_checks++;
    if (done !== 1'b1 || stall !== 1'b0 || bus_if.d_req !== 1'b0 || data_load !== exp) begin
      $display("FAIL %s_done: got done=%b stall=%b req=%b data=%h expected 1 0 0 %h",
               name, done, stall, bus_if.d_req, data_load, exp);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (done !== 1'b0) begin
      $display("FAIL %s_done_pulse: got done=%b expected 0", name, done);
      n_fail++;
    end
  endtask

  task automatic test_loads();
    do_load("lw",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h0000_0103, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h8012_3456, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_0102, 32'h8001_5555, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0100, 32'h1234_F00D, 32'h0000_F00D);
    do_load("lb1", 3'b000, 32'h0000_0041, 32'h0000_7F00, 32'h0000_007F);
  endtask

  // SH with three wait cycles: bus must stay stable and stall high until ack
  task automatic test_store_wait();
    drive_start(OP_STORE, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (stall !== 1'b1 || bus_if.d_req !== 1'b1 || bus_if.d_we !== 1'b1 ||
          bus_if.d_addr !== 32'h20 || bus_if.d_be !== 4'b1100 || bus_if.d_wdata !== 32'hABCD_ABCD) begin
        $display("FAIL sh_wait_c%0d: got stall=%b req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 1 00000020 1100 abcdabcd",
                 c, stall, bus_if.d_req, bus_if.d_we, bus_if.d_addr, bus_if.d_be, bus_if.d_wdata);
        n_fail++;
      end
      if (c == 4) bus_if.d_ack = 1'b1;
      next_cycle();
    end
    n_checks++;
    if (done !== 1'b1 || stall !== 1'b0 || bus_if.d_req !== 1'b0 || data_load !== 32'h0000_007F) begin
      $display("FAIL sh_done: got done=%b stall=%b req=%b data=%h expected 1 0 0 0000007f",
               done, stall, bus_if.d_req, data_load);
      n_fail++;
    end
    next_cycle();
  endtask

  // SB and SW lane placement
  task automatic test_store_lanes();
    drive_start(OP_STORE, 3'b000, 32'h0000_0101, 32'h5566_77EF);
    next_cycle();
    n_checks++;
    if (bus_if.d_be !== 4'b0010 || bus_if.d_wdata !== 32'hEFEF_EFEF || bus_if.d_addr !== 32'h100) begin
      $display("FAIL sb_lanes: got be=%b wdata=%h addr=%h expected 0010 efefefef 00000100",
               bus_if.d_be, bus_if.d_wdata, bus_if.d_addr);
      n_fail++;
    end
    bus_if.d_ack = 1'b1;
    next_cycle();
    next_cycle();
    drive_start(OP_STORE, 3'b010, 32'h0000_0208, 32'hCAFE_F00D);
    next_cycle();
    n_checks++;
    if (bus_if.d_be !== 4'b1111 || bus_if.d_wdata !== 32'hCAFE_F00D || bus_if.d_addr !== 32'h208) begin
      $display("FAIL sw_lanes: got be=%b wdata=%h addr=%h expected 1111 cafef00d 00000208",
               bus_if.d_be, bus_if.d_wdata, bus_if.d_addr);
      n_fail++;
    end
    bus_if.d_ack = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  // Misaligned / illegal requests fault without any bus activity
  task automatic do_fault(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a);
    drive_start(op, f3, a, 32'h0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      $display("FAIL %s_stall: got %b expected 0", name, stall);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (fault !== 1'b1 || bus_if.d_req !== 1'b0 || stall !== 1'b0 || data_load !== 32'h0000_007F) begin
      $display("FAIL %s_pulse: got fault=%b req=%b stall=%b data=%h expected 1 0 0 0000007f",
               name, fault, bus_if.d_req, stall, data_load);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (fault !== 1'b0 || bus_if.d_req !== 1'b0) begin
      $display("FAIL %s_after: got fault=%b req=%b expected 0 0", name, fault, bus_if.d_req);
      n_fail++;
    end
  endtask

  task automatic test_faults();
    do_fault("lw_mis",   OP_LOAD,  3'b010, 32'h0000_0102);
    do_fault("ld_f3_011", OP_LOAD, 3'b011, 32'h0000_0100);
    do_fault("sh_mis",   OP_STORE, 3'b001, 32'h0000_0021);
    do_fault("st_f3_100", OP_STORE, 3'b100, 32'h0000_0100);
    // Non-memory opcode: nothing at all happens
    drive_start(OP_ALU, 3'b010, 32'h0000_0102, 32'h0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      $display("FAIL alu_stall: got %b expected 0", stall);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if ({fault, done, bus_err, bus_if.d_req} !== 4'b0000) begin
      $display("FAIL alu_noop: got fault/done/bus_err/req=%b expected 0000",
               {fault, done, bus_err, bus_if.d_req});
      n_fail++;
    end
    // Ack while idle is ignored
    bus_if.d_ack = 1'b1;
    next_cycle();
    n_checks++;
    if (done !== 1'b0 || data_load !== 32'h0000_007F) begin
      $display("FAIL idle_ack: got done=%b data=%h expected 0 0000007f", done, data_load);
      n_fail++;
    end
  endtask

  // New request in the done cycle; start during REQ is ignored
  task automatic test_back_to_back();
    drive_start(OP_LOAD, 3'b010, 32'h0000_0200, 32'h0);
    next_cycle();
    bus_if.d_ack   = 1'b1;
    bus_if.d_rdata = 32'h1111_1111;
    next_cycle();
    drive_start(OP_LOAD, 3'b100, 32'h0000_0201, 32'h0);
    #1;
    n_checks++;
    if (done !== 1'b1 || stall !== 1'b1 || data_load !== 32'h1111_1111) begin
      $display("FAIL b2b_first: got done=%b stall=%b data=%h expected 1 1 11111111",
               done, stall, data_load);
      n_fail++;
    end
    next_cycle();
    drive_start(OP_STORE, 3'b010, 32'h0000_0300, 32'h9999_9999);
    bus_if.d_ack   = 1'b1;
    bus_if.d_rdata = 32'h0000_AB00;
    n_checks++;
    if (bus_if.d_req !== 1'b1 || bus_if.d_addr !== 32'h200 || bus_if.d_we !== 1'b0) begin
      $display("FAIL b2b_second_bus: got req=%b addr=%h we=%b expected 1 00000200 0",
               bus_if.d_req, bus_if.d_addr, bus_if.d_we);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (done !== 1'b1 || data_load !== 32'h0000_00AB) begin
      $display("FAIL b2b_second_done: got done=%b data=%h expected 1 000000ab", done, data_load);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (bus_if.d_req !== 1'b0 || done !== 1'b0) begin
      $display("FAIL b2b_ignored_start: got req=%b done=%b expected 0 0", bus_if.d_req, done);
      n_fail++;
    end
  endtask

  // Watchdog abort when built with the timeout; otherwise REQ waits forever
  task automatic test_no_ack();
    drive_start(OP_LOAD, 3'b010, 32'h0000_0400, 32'h0);
    next_cycle();
`ifdef LS_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (bus_if.d_req !== 1'b1 || bus_err !== 1'b0) begin
        $display("FAIL to_wait_c%0d: got req=%b bus_err=%b expected 1 0", c, bus_if.d_req, bus_err);
        n_fail++;
      end
      next_cycle();
    end
    n_checks++;
    if (bus_err !== 1'b1 || bus_if.d_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL to_abort: got bus_err=%b req=%b done=%b stall=%b expected 1 0 0 0",
               bus_err, bus_if.d_req, done, stall);
      n_fail++;
    end
    next_cycle();
    n_checks++;
    if (bus_err !== 1'b0 || data_load !== 32'h0000_00AB) begin
      $display("FAIL to_after: got bus_err=%b data=%h expected 0 000000ab", bus_err, data_load);
      n_fail++;
    end
`else
    repeat (20) next_cycle();
    n_checks++;
    if (bus_if.d_req !== 1'b1 || stall !== 1'b1 || bus_err !== 1'b0) begin
      $display("FAIL long_wait: got req=%b stall=%b bus_err=%b expected 1 1 0",
               bus_if.d_req, stall, bus_err);
      n_fail++;
    end
    bus_if.d_ack   = 1'b1;
    bus_if.d_rdata = 32'h7654_3210;
    next_cycle();
    n_checks++;
    if (done !== 1'b1 || data_load !== 32'h7654_3210) begin
      $display("FAIL long_wait_done: got done=%b data=%h expected 1 76543210", done, data_load);
      n_fail++;
    end
    next_cycle();
`endif
  endtask

  // Asynchronous reset in REQ drops d_req at once; later ack is ignored
  task automatic test_reset_mid();
    drive_start(OP_LOAD, 3'b010, 32'h0000_0500, 32'h0);
    next_cycle();
    n_checks++;
    if (bus_if.d_req !== 1'b1) begin
      $display("FAIL rst_mid_req: got %b expected 1", bus_if.d_req);
      n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.d_req !== 1'b0 || stall !== 1'b0 || data_load !== 32'h0) begin
      $display("FAIL rst_mid_drop: got req=%b stall=%b data=%h expected 0 0 00000000",
               bus_if.d_req, stall, data_load);
      n_fail++;
    end
    #2 rst_n = 1'b1;
    next_cycle();
    bus_if.d_ack   = 1'b1;
    bus_if.d_rdata = 32'hFFFF_FFFF;
    next_cycle();
    n_checks++;
    if (done !== 1'b0 || bus_if.d_req !== 1'b0 || data_load !== 32'h0) begin
      $display("FAIL rst_mid_ack: got done=%b req=%b data=%h expected 0 0 00000000",
               done, bus_if.d_req, data_load);
      n_fail++;
    end
  endtask

  initial begin
    start          = 1'b0;
    opcode         = 7'h0;
    funct3         = 3'h0;
    addr           = 32'h0;
    rs2            = 32'h0;
    bus_if.d_ack   = 1'b0;
    bus_if.d_rdata = 32'h0;
    test_reset();
    test_loads();
    test_store_wait();
    test_store_lanes();
    test_faults();
    test_back_to_back();
    test_no_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
